// File: rtl/fifo_pkt_pkg.sv
// Shared types and helpers for the FIFO drain packetizer.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECKSUM
    } pkt_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Header beat payload: sync byte, sequence number, payload length.
    function automatic logic [31:0] make_header(input logic [7:0] seq, input logic [15:0] len);
        return {SYNC_BYTE, seq, len};
    endfunction

endpackage

// File: rtl/fifo_drain_packetizer.sv
// Pops words from the async FIFO read side and frames them as
// header / PKT_LEN payload words / checksum on a registered valid/ready stream.
module fifo_drain_packetizer
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] pkt_data,
    output logic                  pkt_valid,
    input  logic                  pkt_ready,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [15:0]           pkt_count
);

    localparam logic [15:0] LEN_FIELD = 16'(PKT_LEN);
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    pkt_state_t            state;
    pkt_state_t            state_nxt;
    logic [7:0]            seq;
    logic [DATA_WIDTH-1:0] sum;
    logic [15:0]           beat_cnt;

    logic                  avail;
    logic                  slot_free;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_sop;
    logic                  load_eop;

    // fifo_empty lags the last pop by a cycle, so the current-cycle flag gates too.
    assign avail     = !fifo_empty && !fifo_almost_empty;
    assign slot_free = !pkt_valid || pkt_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, pop request and output-register load selection.
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        load_data  = '0;
        load_sop   = 1'b0;
        load_eop   = 1'b0;
        fifo_rd_en = 1'b0;
        unique case (state)
            IDLE: begin
                // Header only goes out once a payload word is already waiting.
                if (avail && slot_free) begin
                    load      = 1'b1;
                    load_data = DATA_WIDTH'(make_header(seq, LEN_FIELD));
                    load_sop  = 1'b1;
                    state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (avail && slot_free) begin
                    fifo_rd_en = 1'b1;
                    load       = 1'b1;
                    load_data  = fifo_data;
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = CHECKSUM;
                    end
                end
            end
            CHECKSUM: begin
                if (slot_free) begin
                    load      = 1'b1;
                    load_data = sum;
                    load_eop  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Payload accumulation, beat counting and sequence numbering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum      <= '0;
            beat_cnt <= '0;
            seq      <= '0;
        end else if (load && state == PAYLOAD) begin
            sum      <= sum + fifo_data;
            beat_cnt <= beat_cnt + 16'd1;
        end else if (load && state == CHECKSUM) begin
            sum      <= '0;
            beat_cnt <= '0;
            seq      <= seq + 8'd1;
        end
    end

    // Output beat register: reload when the slot is free, else hold or drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            pkt_sop   <= 1'b0;
            pkt_eop   <= 1'b0;
        end else if (load) begin
            pkt_valid <= 1'b1;
            pkt_data  <= load_data;
            pkt_sop   <= load_sop;
            pkt_eop   <= load_eop;
        end else if (pkt_ready) begin
            pkt_valid <= 1'b0;
        end
    end

    // Completed-packet counter, stepped when a checksum beat is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (pkt_valid && pkt_ready && pkt_eop) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_drain_packetizer.sv
// Bench for fifo_drain_packetizer: behavioural FIFO, packet-stream scoreboard,
// directed sequences, a vector table and a randomized long run.
module tb_fifo_drain_packetizer;

    localparam int PKT_LEN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fifo_data;
    logic        fifo_empty = 1'b1;
    logic        fifo_almost_empty;
    logic        fifo_rd_en;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic        pkt_sop;
    logic        pkt_eop;
    logic [15:0] pkt_count;

    fifo_drain_packetizer #(.DATA_WIDTH(32), .PKT_LEN(PKT_LEN)) dut (
        .clk(clk), .reset(reset),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_almost_empty(fifo_almost_empty), .fifo_rd_en(fifo_rd_en),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_sop(pkt_sop), .pkt_eop(pkt_eop), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: asynchronous read, registered empty, current-cycle almost_empty.
    logic [31:0] mem [0:2047];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_data         = mem[rd_ptr[10:0]];
    assign fifo_almost_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        fifo_empty <= (wr_ptr == rd_ptr);
        if (fifo_rd_en && (wr_ptr != rd_ptr)) rd_ptr <= rd_ptr + 1;
    end

    // Scoreboard state: packet stream expected from the words pushed so far.
    int          vec = 0;
    int          miss = 0;
    int          pops = 0;
    logic [31:0] m_words[$];
    int          m_pos = 0;
    logic [7:0]  m_seq = 0;
    logic [31:0] m_sum = 0;
    logic [15:0] m_count = 0;
    int          m_idx = 0;
    logic [31:0] last_hdr = 0;
    logic [31:0] last_cks = 0;
    logic [31:0] hdr257 = 0;
    logic        prev_stall = 0;
    logic [31:0] prev_data = 0;
    logic [1:0]  prev_flags = 0;

    typedef struct {
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] hdr;
        logic [31:0] cks;
    } vec_t;
    vec_t tbl[5];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[10:0]] = w;
        wr_ptr++;
        m_words.push_back(w);
    endtask

    task automatic model_clear();
        m_words.delete();
        m_pos = 0; m_seq = 0; m_sum = 0; m_count = 0; m_idx = 0;
        hdr257 = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic monitor();
        logic [31:0] exp_d;
        logic        exp_sop, exp_eop;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 64'(pkt_valid), 64'd1);
                    chk("hold_data", 64'(pkt_data), 64'(prev_data));
                    chk("hold_flags", 64'({pkt_sop, pkt_eop}), 64'(prev_flags));
                end
                if (fifo_rd_en) begin
                    pops++;
                    chk("pop_while_empty", 64'(fifo_empty | fifo_almost_empty), 64'd0);
                end
                chk("pkt_count", 64'(pkt_count), 64'(m_count));
                if (pkt_valid && pkt_ready) begin
                    exp_sop = 1'b0;
                    exp_eop = 1'b0;
                    if (m_pos == 0) begin
                        exp_d   = {8'hA5, m_seq, 16'(PKT_LEN)};
                        exp_sop = 1'b1;
                    end else if (m_pos <= PKT_LEN) begin
                        if (m_words.size() == 0) begin
                            vec++; miss++;
                            $display("FAIL payload_source: beat %0h with no pushed word left", pkt_data);
                            exp_d = pkt_data;
                        end else begin
                            exp_d = m_words.pop_front();
                        end
                    end else begin
                        exp_d   = m_sum;
                        exp_eop = 1'b1;
                    end
                    chk("beat_data", 64'(pkt_data), 64'(exp_d));
                    chk("beat_sop_eop", 64'({pkt_sop, pkt_eop}), 64'({exp_sop, exp_eop}));
                    if (m_pos == 0) begin
                        last_hdr = pkt_data;
                        if (m_idx == 256) hdr257 = pkt_data;
                        m_pos = 1;
                    end else if (m_pos <= PKT_LEN) begin
                        m_sum = m_sum + exp_d;
                        m_pos++;
                    end else begin
                        last_cks = pkt_data;
                        m_count++;
                        m_seq++;
                        m_sum = 0;
                        m_pos = 0;
                        m_idx++;
                    end
                end
                prev_stall = pkt_valid && !pkt_ready;
                prev_data  = pkt_data;
                prev_flags = {pkt_sop, pkt_eop};
            end
        end
    endtask

    task automatic wait_pkts(input logic [15:0] target, input int budget);
        int n = 0;
        while (m_count != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("pkt_done_in_time", 64'(m_count), 64'(target));
    endtask

    task automatic wait_sop(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(pkt_valid && pkt_sop) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("sop_in_time", 64'(pkt_valid && pkt_sop), 64'd1);
    endtask

    initial begin
        int          p0;
        logic [15:0] c0;
        int          pushed;
        int          cyc;

        tbl[0] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'hA500_0004, 32'h0000_000A};
        tbl[1] = '{32'd5, 32'd6, 32'd7, 32'd8, 32'hA501_0004, 32'h0000_001A};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hA502_0004, 32'hFFFF_FFFC};
        tbl[3] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hA503_0004, 32'h0000_0000};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 32'd1, 32'd2, 32'hA504_0004, 32'h0000_0003};

        fork
            monitor();
        join_none

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_data", 64'(pkt_data), 64'd0);
        chk("rst_sop", 64'(pkt_sop), 64'd0);
        chk("rst_eop", 64'(pkt_eop), 64'd0);
        chk("rst_count", 64'(pkt_count), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single packet, exact cycle-by-cycle stream and latency.
        @(posedge clk); #1;
        p0 = pops;
        for (int k = 1; k <= 4; k++) push(32'(k));
        @(negedge clk);
        chk("lat_n0_valid", 64'(pkt_valid), 64'd0);
        @(negedge clk);
        chk("lat_n1_valid", 64'(pkt_valid), 64'd0);
        @(negedge clk);
        chk("p1_hdr_valid", 64'(pkt_valid), 64'd1);
        chk("p1_hdr_sop", 64'(pkt_sop), 64'd1);
        chk("p1_hdr_data", 64'(pkt_data), 64'hA500_0004);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("p1_pay_valid", 64'(pkt_valid), 64'd1);
            chk("p1_pay_data", 64'(pkt_data), 64'(k));
            chk("p1_pay_flags", 64'({pkt_sop, pkt_eop}), 64'd0);
        end
        @(negedge clk);
        chk("p1_cks_data", 64'(pkt_data), 64'h0000_000A);
        chk("p1_cks_eop", 64'(pkt_eop), 64'd1);
        @(negedge clk);
        chk("p1_count", 64'(pkt_count), 64'd1);
        chk("p1_idle_valid", 64'(pkt_valid), 64'd0);
        chk("p1_pops", 64'(pops - p0), 64'd4);

        // Two back-to-back packets with no bubble.
        do_reset();
        for (int k = 1; k <= 8; k++) push(32'(k));
        wait_sop(10);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            chk("b2b_valid", 64'(pkt_valid), 64'd1);
        end
        @(negedge clk);
        chk("b2b_hdr2", 64'(last_hdr), 64'hA501_0004);
        chk("b2b_cks2", 64'(last_cks), 64'h0000_001A);
        chk("b2b_count", 64'(pkt_count), 64'd2);

        // Downstream stall mid-payload.
        @(posedge clk); #1;
        push(32'd10); push(32'd20); push(32'd30); push(32'd40);
        c0 = m_count;
        wait_sop(10);
        @(negedge clk);
        @(posedge clk); #1;
        pkt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", 64'(pkt_data), 64'd20);
            chk("stall_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        @(posedge clk); #1;
        pkt_ready = 1'b1;
        wait_pkts(c0 + 16'd1, 30);
        chk("stall_cks", 64'(last_cks), 64'd100);

        // FIFO drains after two words, refilled later.
        @(posedge clk); #1;
        p0 = pops;
        c0 = m_count;
        push(32'd7); push(32'd9);
        repeat (14) @(negedge clk);
        chk("drain_pops", 64'(pops - p0), 64'd2);
        chk("drain_count", 64'(pkt_count), 64'(c0));
        chk("drain_valid", 64'(pkt_valid), 64'd0);
        @(posedge clk); #1;
        push(32'd11); push(32'd13);
        wait_pkts(c0 + 16'd1, 30);
        chk("drain_cks", 64'(last_cks), 64'd40);
        chk("drain_pops_total", 64'(pops - p0), 64'd4);

        // Reset in PAYLOAD after two payload beats.
        @(posedge clk); #1;
        push(32'd3); push(32'd5);
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(pkt_valid), 64'd0);
        chk("mid_rst_data", 64'(pkt_data), 64'd0);
        chk("mid_rst_flags", 64'({pkt_sop, pkt_eop}), 64'd0);
        chk("mid_rst_count", 64'(pkt_count), 64'd0);
        chk("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
        push(32'd1); push(32'd1); push(32'd1); push(32'd1);
        wait_pkts(16'd1, 30);
        chk("after_rst_hdr", 64'(last_hdr), 64'hA500_0004);
        chk("after_rst_cks", 64'(last_cks), 64'd4);

        // Vector table of packets.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            push(tbl[i].w0); push(tbl[i].w1); push(tbl[i].w2); push(tbl[i].w3);
            wait_pkts(16'(i + 1), 40);
            chk("tbl_hdr", 64'(last_hdr), 64'(tbl[i].hdr));
            chk("tbl_cks", 64'(last_cks), 64'(tbl[i].cks));
        end

        // Randomized words and backpressure across the sequence-number wrap.
        do_reset();
        pushed = 0;
        cyc = 0;
        while (m_count < 16'd257 && cyc < 20000) begin
            @(posedge clk); #1;
            pkt_ready = ($urandom_range(0, 3) != 0);
            if (pushed < 257 * PKT_LEN && $urandom_range(0, 1) == 1) begin
                push($urandom);
                pushed++;
            end
            cyc++;
        end
        pkt_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rand_count", 64'(pkt_count), 64'd257);
        chk("seq_wrap_hdr", 64'(hdr257), 64'hA500_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
